// File: rtl/psum_buffer.sv
// Partial-sum store for the psum adder tree: feeds the stored accumulator
// operand, captures write-back, and holds finished sums on a valid/ready port.
module psum_buffer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int AW     = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall_in,
   output logic              stall,
   input  logic              cfg_load,
   input  logic [AW:0]       cfg_row_len,
   input  logic              issue_valid,
   input  logic              issue_first,
   input  logic              issue_last,
   output logic [DATA_W-1:0] fifo_data,
   input  logic [DATA_W-1:0] add_out,
   output logic [DATA_W-1:0] res_data,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              row_done
);

   localparam logic [AW:0]   LP_DEPTH  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LP_ONE_L  = (AW+1)'(1);
   localparam logic [AW-1:0] LP_ONE_A  = AW'(1);

   logic [AW:0]       r_row_len;
   logic [AW-1:0]     r_pos;

   logic              r_s1_v, r_s1_first, r_s1_last;
   logic [AW-1:0]     r_s1_addr;
   logic              r_s2_v, r_s2_first, r_s2_last;
   logic [AW-1:0]     r_s2_addr;
   logic              r_s3_v, r_s3_last;
   logic [AW-1:0]     r_s3_addr;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_res_data;
   logic              r_res_valid;

   logic              w_stall;
   logic              w_issue;
   logic [AW:0]       w_cfg_len;
   logic [AW:0]       w_len_eff;
   logic [AW-1:0]     w_pos_eff;
   logic              w_wrap;
   logic              w_s3_wr;
   logic              w_res_load;
   logic              w_res_pop;
   logic [DATA_W-1:0] w_fifo;

   assign w_stall   = stall_in | (r_res_valid & ~res_ready);
   assign w_issue   = issue_valid & ~w_stall;

   // A config load in the same cycle as an issue takes effect for that issue.
   assign w_cfg_len = ((cfg_row_len == '0) || (cfg_row_len > LP_DEPTH)) ? LP_DEPTH : cfg_row_len;
   assign w_len_eff = cfg_load ? w_cfg_len : r_row_len;
   assign w_pos_eff = cfg_load ? '0 : r_pos;
   assign w_wrap    = ({1'b0, w_pos_eff} == (w_len_eff - LP_ONE_L));

   assign w_s3_wr    = r_s3_v & ~r_s3_last;
   assign w_res_load = r_s3_v & r_s3_last & ~w_stall;
   assign w_res_pop  = r_res_valid & res_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row_len <= LP_DEPTH;
         r_pos     <= '0;
      end else if (!w_stall) begin
         if (cfg_load)
            r_row_len <= w_cfg_len;
         if (w_issue)
            r_pos <= w_wrap ? '0 : (w_pos_eff + LP_ONE_A);
         else if (cfg_load)
            r_pos <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_v     <= 1'b0;
         r_s1_first <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_addr  <= '0;
         r_s2_v     <= 1'b0;
         r_s2_first <= 1'b0;
         r_s2_last  <= 1'b0;
         r_s2_addr  <= '0;
         r_s3_v     <= 1'b0;
         r_s3_last  <= 1'b0;
         r_s3_addr  <= '0;
      end else if (!w_stall) begin
         r_s1_v     <= issue_valid;
         r_s1_first <= issue_first;
         r_s1_last  <= issue_last;
         r_s1_addr  <= w_pos_eff;
         r_s2_v     <= r_s1_v;
         r_s2_first <= r_s1_first;
         r_s2_last  <= r_s1_last;
         r_s2_addr  <= r_s1_addr;
         r_s3_v     <= r_s2_v;
         r_s3_last  <= r_s2_last;
         r_s3_addr  <= r_s2_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (w_s3_wr && !w_stall)
         r_mem[r_s3_addr] <= add_out;
   end

   // S3 writing the address S2 reads means the sum has not reached memory yet.
   always_comb begin
      w_fifo = '0;
      if (r_s2_v && !r_s2_first) begin
         if (w_s3_wr && (r_s3_addr == r_s2_addr))
            w_fifo = add_out;
         else
            w_fifo = r_mem[r_s2_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res_data  <= '0;
         r_res_valid <= 1'b0;
      end else if (w_res_load) begin
         r_res_data  <= add_out;
         r_res_valid <= 1'b1;
      end else if (w_res_pop) begin
         r_res_valid <= 1'b0;
      end
   end

   assign stall     = w_stall;
   assign fifo_data = w_fifo;
   assign res_data  = r_res_data;
   assign res_valid = r_res_valid;
   assign row_done  = w_issue & w_wrap;

endmodule
